charlieplex_pwm_scanner: RTL and testbench

Parametrised, double-buffered charlieplex scanner with per-LED PWM brightness, driving BANKS independent charlieplex pin groups in parallel. It replaces the fixed 9-pin, two-row driver plus separate PWM generator. A pattern source such as the game-of-life or PWM generator writes brightness values into a back buffer and requests a swap. The scanner displays the front buffer and commits swaps only at frame boundaries, so frames never tear. Tri-state pads stay in the top level, which builds them from `pin_oe`/`pin_out`.

---
 rtl/charlieplex_pwm_scanner.sv | 122 ++++++++++++
 tb/tb_charlieplex_pwm_scanner.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/charlieplex_pwm_scanner.sv
// Double-buffered charlieplex scanner with per-LED PWM brightness.
// BANKS pin groups are scanned in lockstep; the front buffer is displayed
// while the back buffer takes writes, and swaps commit only at frame wrap.
module charlieplex_pwm_scanner #(
   parameter  int unsigned PINS     = 9,
   parameter  int unsigned BANKS    = 2,
   parameter  int unsigned PWM_BITS = 4,
   parameter  int unsigned BLANK    = 1,
   localparam int unsigned LEDS     = PINS * (PINS - 1),
   localparam int unsigned AW       = $clog2(BANKS * LEDS),
   localparam int unsigned SW       = $clog2(LEDS)
) (
   input  logic                  clock,
   input  logic                  aclr,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [PWM_BITS-1:0]   wr_data,
   input  logic                  swap,
   output logic                  swap_pending,
   output logic                  frame_done,
   output logic [SW-1:0]         scan_slot,
   output logic [BANKS*PINS-1:0] pin_oe,
   output logic [BANKS*PINS-1:0] pin_out
);

   localparam int unsigned NENT   = BANKS * LEDS;
   localparam int unsigned TCOUNT = (2 ** PWM_BITS) + BLANK;
   localparam int unsigned TW     = $clog2(TCOUNT);
   localparam int unsigned PW     = $clog2(PINS);

   localparam logic [TW-1:0]   TMAX   = TW'(TCOUNT - 1);
   localparam logic [TW-1:0]   ACTIVE = TW'(2 ** PWM_BITS);
   localparam logic [SW-1:0]   SMAX   = SW'(LEDS - 1);
   localparam logic [SW-1:0]   ROWLEN = SW'(PINS - 1);
   localparam logic [PINS-1:0] ONE    = PINS'(1);

   logic [TW-1:0]       tick;
   logic [SW-1:0]       slot;
   logic                front_sel;
   logic                wrap;
   logic [PWM_BITS-1:0] buffer0 [NENT];
   logic [PWM_BITS-1:0] buffer1 [NENT];

   logic [PW-1:0]         anode;
   logic [PW-1:0]         kidx;
   logic [PW-1:0]         cathode;
   logic [BANKS*PINS-1:0] oe_nxt;
   logic [BANKS*PINS-1:0] out_nxt;

   // Decode the current slot into its anode/cathode pin pair
   always_comb begin
      anode   = PW'(slot / ROWLEN);
      kidx    = PW'(slot % ROWLEN);
      cathode = (kidx < anode) ? kidx : kidx + 1'b1;
      wrap    = (tick == TMAX) && (slot == SMAX);
   end

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      localparam logic [AW-1:0] BASE = AW'(b * LEDS);

      logic [PWM_BITS-1:0] level;
      logic                lit;

      // Fetch this bank's front-buffer brightness and compare against the PWM tick
      always_comb begin
         level = front_sel ? buffer1[BASE + AW'(slot)] : buffer0[BASE + AW'(slot)];
         lit   = (tick < ACTIVE) && (tick < TW'(level));
      end

      assign oe_nxt[b*PINS +: PINS]  = lit ? ((ONE << anode) | (ONE << cathode)) : '0;
      assign out_nxt[b*PINS +: PINS] = lit ? (ONE << anode) : '0;
   end

   // Scan counters, swap bookkeeping and registered pin drive
   always_ff @(posedge clock) begin
      if (aclr) begin
         tick         <= '0;
         slot         <= '0;
         front_sel    <= 1'b0;
         swap_pending <= 1'b0;
         frame_done   <= 1'b0;
         scan_slot    <= '0;
         pin_oe       <= '0;
         pin_out      <= '0;
      end else begin
         pin_oe     <= oe_nxt;
         pin_out    <= out_nxt;
         scan_slot  <= slot;
         frame_done <= wrap;

         if (tick == TMAX) begin
            tick <= '0;
            slot <= (slot == SMAX) ? '0 : slot + 1'b1;
         end else begin
            tick <= tick + 1'b1;
         end

         // a swap arriving on the commit edge is absorbed by that commit
         if (wrap && swap_pending) begin
            front_sel    <= ~front_sel;
            swap_pending <= 1'b0;
         end else if (swap) begin
            swap_pending <= 1'b1;
         end
      end
   end

   // Back-buffer writes; the buffer not selected by front_sel takes the data
   always_ff @(posedge clock) begin
      if (aclr) begin
         buffer0 <= '{default: '0};
         buffer1 <= '{default: '0};
      end else if (wr_en && (32'(wr_addr) < NENT)) begin
         if (front_sel) begin
            buffer0[wr_addr] <= wr_data;
         end else begin
            buffer1[wr_addr] <= wr_data;
         end
      end
   end

endmodule

// File: tb/tb_charlieplex_pwm_scanner.sv
// Self-checking bench for charlieplex_pwm_scanner at default parameters.
// A cycle model pushes the expected registered outputs into a scoreboard
// queue as each cycle's stimulus is applied; a monitor pops and compares.
module tb_charlieplex_pwm_scanner;

   localparam int PINS   = 9;
   localparam int BANKS  = 2;
   localparam int LEDS   = 72;
   localparam int NENT   = 144;
   localparam int TCOUNT = 17;
   localparam int ACTIVE = 16;
   localparam int FRAME  = LEDS * TCOUNT;

   logic                  clock = 1'b0;
   logic                  aclr = 1'b1;
   logic                  wr_en = 1'b0;
   logic [7:0]            wr_addr = '0;
   logic [3:0]            wr_data = '0;
   logic                  swap = 1'b0;
   logic                  swap_pending;
   logic                  frame_done;
   logic [6:0]            scan_slot;
   logic [BANKS*PINS-1:0] pin_oe;
   logic [BANKS*PINS-1:0] pin_out;

   charlieplex_pwm_scanner #(
      .PINS     (9),
      .BANKS    (2),
      .PWM_BITS (4),
      .BLANK    (1)
   ) dut (
      .clock        (clock),
      .aclr         (aclr),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .swap         (swap),
      .swap_pending (swap_pending),
      .frame_done   (frame_done),
      .scan_slot    (scan_slot),
      .pin_oe       (pin_oe),
      .pin_out      (pin_out)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [17:0] oe;
      logic [17:0] out;
      logic [6:0]  scan;
      logic        fd;
      logic        pend;
   } exp_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   int m_buf0 [NENT];
   int m_buf1 [NENT];
   bit m_front, m_pend;
   int m_tick, m_slot;
   int tab_a [LEDS];
   int tab_c [LEDS];

   // Scoreboard consumer: compare DUT outputs 1 time unit after each edge
   always @(posedge clock) begin
      #1;
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         n_cmp++;
         if ({pin_oe, pin_out, scan_slot, frame_done, swap_pending} !== mon_e) begin
            n_bad++;
            $display("FAIL scoreboard t=%0t oe=%h exp %h out=%h exp %h scan=%0d exp %0d fd=%b exp %b pend=%b exp %b",
                     $time, pin_oe, mon_e.oe, pin_out, mon_e.out, scan_slot, mon_e.scan,
                     frame_done, mon_e.fd, swap_pending, mon_e.pend);
         end
      end
   end

   // Apply current inputs for one cycle: model the edge, push expectation, wait
   task automatic cyc();
      exp_t e;
      bit   wrap;
      int   v;
      e = '0;
      if (aclr) begin
         for (int i = 0; i < NENT; i++) begin
            m_buf0[i] = 0;
            m_buf1[i] = 0;
         end
         m_front = 1'b0; m_pend = 1'b0; m_tick = 0; m_slot = 0;
      end else begin
         for (int b = 0; b < BANKS; b++) begin
            v = m_front ? m_buf1[b*LEDS + m_slot] : m_buf0[b*LEDS + m_slot];
            if (m_tick < ACTIVE && m_tick < v) begin
               e.oe[b*PINS + tab_a[m_slot]]  = 1'b1;
               e.oe[b*PINS + tab_c[m_slot]]  = 1'b1;
               e.out[b*PINS + tab_a[m_slot]] = 1'b1;
            end
         end
         e.scan = 7'(m_slot);
         wrap   = (m_tick == TCOUNT-1) && (m_slot == LEDS-1);
         e.fd   = wrap;
         if (wr_en && int'(wr_addr) < NENT) begin
            if (m_front) m_buf0[wr_addr] = int'(wr_data);
            else         m_buf1[wr_addr] = int'(wr_data);
         end
         if (wrap && m_pend) begin
            m_front = !m_front;
            m_pend  = 1'b0;
         end else if (swap) begin
            m_pend = 1'b1;
         end
         e.pend = m_pend;
         if (m_tick == TCOUNT-1) begin
            m_tick = 0;
            m_slot = (m_slot == LEDS-1) ? 0 : m_slot + 1;
         end else begin
            m_tick++;
         end
      end
      sb_q.push_back(e);
      @(negedge clock);
   endtask

   task automatic write(input int addr, input int data);
      wr_en = 1'b1; wr_addr = 8'(addr); wr_data = 4'(data);
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic pulse_swap();
      swap = 1'b1;
      cyc();
      swap = 1'b0;
   endtask

   // Run until a frame_done sample appears, bounded by a little over a frame
   task automatic wait_frame(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < FRAME + 20; i++) begin
         cyc();
         if (frame_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Sample one full frame; report activity and pattern hits per bank
   task automatic observe_frame(input int a0, input int c0, input int a1, input int c1,
                                output int any0, output int any1, output int hit0, output int hit1,
                                output int first0, output int first1, output int viol,
                                output int fd_cnt, output bit fd_last);
      logic [8:0] oe0, oe1, out0, out1;
      any0 = 0; any1 = 0; hit0 = 0; hit1 = 0; first0 = -1; first1 = -1;
      viol = 0; fd_cnt = 0; fd_last = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         cyc();
         oe0 = pin_oe[8:0];  oe1 = pin_oe[17:9];
         out0 = pin_out[8:0]; out1 = pin_out[17:9];
         if (oe0 != 0) begin any0++; if (first0 < 0) first0 = i; end
         if (oe1 != 0) begin any1++; if (first1 < 0) first1 = i; end
         if (a0 >= 0 && oe0 == ((9'd1 << a0) | (9'd1 << c0)) && out0 == (9'd1 << a0)) hit0++;
         if (a1 >= 0 && oe1 == ((9'd1 << a1) | (9'd1 << c1)) && out1 == (9'd1 << a1)) hit1++;
         if ($countones(oe0) > 2 || $countones(oe1) > 2) viol++;
         if (frame_done === 1'b1) fd_cnt++;
         if (i == FRAME-1) fd_last = frame_done;
      end
   endtask

   task automatic test_reset();
      aclr = 1'b1;
      cyc();
      cyc();
      n_cmp++;
      if (pin_oe !== '0 || pin_out !== '0) begin
         n_bad++; $display("FAIL reset_pins oe=%h out=%h required 0", pin_oe, pin_out);
      end
      n_cmp++;
      if ({scan_slot, frame_done, swap_pending} !== '0) begin
         n_bad++; $display("FAIL reset_status scan=%0d fd=%b pend=%b required 0", scan_slot, frame_done, swap_pending);
      end
      aclr = 1'b0;
      cyc();
      n_cmp++;
      if (scan_slot !== 7'd0) begin
         n_bad++; $display("FAIL first_slot scan=%0d required 0", scan_slot);
      end
   endtask

   task automatic test_single_led();
      bit ok, fdl;
      int any0, any1, hit0, hit1, f0, f1, viol, fdc;
      write(0, 15);
      pulse_swap();
      n_cmp++;
      if (swap_pending !== 1'b1) begin
         n_bad++; $display("FAIL pending_rise pend=%b required 1", swap_pending);
      end
      wait_frame(ok);
      n_cmp++;
      if (!ok || swap_pending !== 1'b0) begin
         n_bad++; $display("FAIL single_commit seen=%b pend=%b required 1/0", ok, swap_pending);
      end
      observe_frame(tab_a[0], tab_c[0], -1, -1, any0, any1, hit0, hit1, f0, f1, viol, fdc, fdl);
      n_cmp++;
      if (hit0 != 15 || any0 != 15 || f0 != 0) begin
         n_bad++; $display("FAIL single_lit hits=%0d any=%0d first=%0d required 15/15/0", hit0, any0, f0);
      end
      n_cmp++;
      if (any1 != 0) begin
         n_bad++; $display("FAIL single_bank1 active=%0d required 0", any1);
      end
      n_cmp++;
      if (fdc != 1 || fdl !== 1'b1) begin
         n_bad++; $display("FAIL frame_length pulses=%0d at_end=%b required 1/1", fdc, fdl);
      end
   endtask

   task automatic test_multi_bank();
      bit ok, fdl;
      int any0, any1, hit0, hit1, f0, f1, viol, fdc;
      write(71, 4);
      write(72 + 10, 8);
      pulse_swap();
      wait_frame(ok);
      observe_frame(tab_a[71], tab_c[71], tab_a[10], tab_c[10], any0, any1, hit0, hit1, f0, f1, viol, fdc, fdl);
      n_cmp++;
      if (!ok || hit0 != 4 || any0 != 4 || f0 != 71*TCOUNT) begin
         n_bad++; $display("FAIL bank0_slot71 seen=%b hits=%0d any=%0d first=%0d required 1/4/4/%0d", ok, hit0, any0, f0, 71*TCOUNT);
      end
      n_cmp++;
      if (hit1 != 8 || any1 != 8 || f1 != 10*TCOUNT) begin
         n_bad++; $display("FAIL bank1_slot10 hits=%0d any=%0d first=%0d required 8/8/%0d", hit1, any1, f1, 10*TCOUNT);
      end
      n_cmp++;
      if (viol != 0) begin
         n_bad++; $display("FAIL max_two_pins violations=%0d required 0", viol);
      end
   endtask

   task automatic test_no_swap();
      bit ok, fdl;
      int lit, pend, any0, any1, hit0, hit1, f0, f1, viol, fdc;
      aclr = 1'b1; cyc(); aclr = 1'b0;
      write(5, 7);
      lit = 0; pend = 0;
      for (int i = 0; i < 3*FRAME; i++) begin
         cyc();
         if (pin_oe != '0) lit++;
         if (swap_pending !== 1'b0) pend++;
      end
      n_cmp++;
      if (lit != 0 || pend != 0) begin
         n_bad++; $display("FAIL no_swap_dark lit=%0d pending=%0d required 0/0", lit, pend);
      end
      pulse_swap();
      wait_frame(ok);
      n_cmp++;
      if (!ok || pin_oe !== '0 || swap_pending !== 1'b0) begin
         n_bad++; $display("FAIL late_commit seen=%b oe=%h pend=%b required 1/0/0", ok, pin_oe, swap_pending);
      end
      observe_frame(tab_a[5], tab_c[5], -1, -1, any0, any1, hit0, hit1, f0, f1, viol, fdc, fdl);
      n_cmp++;
      if (hit0 != 7 || any0 != 7 || f0 != 5*TCOUNT) begin
         n_bad++; $display("FAIL after_swap_slot5 hits=%0d any=%0d first=%0d required 7/7/%0d", hit0, any0, f0, 5*TCOUNT);
      end
   endtask

   task automatic test_swap_edges();
      bit ok, fdl;
      int n, any0, any1, hit0, hit1, f0, f1, viol, fdc, any0b, hit0b;
      pulse_swap();
      n = 0;
      while (!(m_tick == TCOUNT-1 && m_slot == LEDS-1) && n < FRAME + 20) begin
         cyc();
         n++;
      end
      pulse_swap();
      n_cmp++;
      if (frame_done !== 1'b1 || swap_pending !== 1'b0) begin
         n_bad++; $display("FAIL swap_on_commit fd=%b pend=%b required 1/0", frame_done, swap_pending);
      end
      observe_frame(tab_a[5], tab_c[5], -1, -1, any0, any1, hit0, hit1, f0, f1, viol, fdc, fdl);
      observe_frame(tab_a[5], tab_c[5], -1, -1, any0b, any1, hit0b, hit1, f0, f1, viol, fdc, fdl);
      n_cmp++;
      if (any0 != 0 || any0b != 0 || swap_pending !== 1'b0) begin
         n_bad++; $display("FAIL single_toggle lit=%0d/%0d pend=%b required 0/0/0", any0, any0b, swap_pending);
      end
      pulse_swap();
      cyc(); cyc(); cyc();
      pulse_swap();
      wait_frame(ok);
      observe_frame(tab_a[5], tab_c[5], -1, -1, any0, any1, hit0, hit1, f0, f1, viol, fdc, fdl);
      observe_frame(tab_a[5], tab_c[5], -1, -1, any0b, any1, hit0b, hit1, f0, f1, viol, fdc, fdl);
      n_cmp++;
      if (!ok || hit0 != 7 || hit0b != 7 || swap_pending !== 1'b0) begin
         n_bad++; $display("FAIL double_swap seen=%b hits=%0d/%0d pend=%b required 1/7/7/0", ok, hit0, hit0b, swap_pending);
      end
   endtask

   task automatic test_out_of_range();
      bit ok, fdl;
      int any0, any1, hit0, hit1, f0, f1, viol, fdc;
      write(144, 15);
      write(255, 15);
      write(143, 3);
      pulse_swap();
      wait_frame(ok);
      observe_frame(-1, -1, tab_a[71], tab_c[71], any0, any1, hit0, hit1, f0, f1, viol, fdc, fdl);
      n_cmp++;
      if (!ok || any0 != 0) begin
         n_bad++; $display("FAIL out_of_range seen=%b bank0_active=%0d required 1/0", ok, any0);
      end
      n_cmp++;
      if (hit1 != 3 || any1 != 3) begin
         n_bad++; $display("FAIL last_addr hits=%0d any=%0d required 3/3", hit1, any1);
      end
   endtask

   task automatic test_reset_mid();
      bit ok, fdl, lit;
      int any0, any1, hit0, hit1, f0, f1, viol, fdc, any0b, any1b;
      lit = 1'b0;
      for (int i = 0; i < FRAME + 20; i++) begin
         cyc();
         if (pin_oe[17:9] != '0) begin
            lit = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!lit) begin
         n_bad++; $display("FAIL pre_reset_lit seen=0 required 1");
      end
      aclr = 1'b1;
      cyc();
      aclr = 1'b0;
      n_cmp++;
      if (pin_oe !== '0 || pin_out !== '0 || scan_slot !== 7'd0) begin
         n_bad++; $display("FAIL mid_reset oe=%h out=%h scan=%0d required 0/0/0", pin_oe, pin_out, scan_slot);
      end
      observe_frame(-1, -1, -1, -1, any0, any1, hit0, hit1, f0, f1, viol, fdc, fdl);
      pulse_swap();
      wait_frame(ok);
      observe_frame(-1, -1, -1, -1, any0b, any1b, hit0, hit1, f0, f1, viol, fdc, fdl);
      n_cmp++;
      if (!ok || any0 != 0 || any1 != 0 || any0b != 0 || any1b != 0) begin
         n_bad++; $display("FAIL buffers_cleared seen=%b active=%0d/%0d/%0d/%0d required 1/0/0/0/0", ok, any0, any1, any0b, any1b);
      end
   endtask

   initial begin
      int s;
      s = 0;
      for (int a = 0; a < PINS; a++) begin
         for (int c = 0; c < PINS; c++) begin
            if (c != a) begin
               tab_a[s] = a;
               tab_c[s] = c;
               s++;
            end
         end
      end
      @(negedge clock);
      test_reset();
      test_single_led();
      test_multi_bank();
      test_no_swap();
      test_swap_edges();
      test_out_of_range();
      test_reset_mid();
      @(posedge clock);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
